// File: rtl/bw_r_frf_mt_pkg.sv
// bw_frf_pkg: shared sizing helpers and half-select constants for the FP register file.
package bw_frf_pkg;

    localparam int HI = 1;
    localparam int LO = 0;

    function automatic int half_w(input int data_w);
        return data_w / 2;
    endfunction

    // A single-entry file still needs a 1-bit address bus.
    function automatic int addr_w(input int nthr, input int nreg);
        return (nthr * nreg > 1) ? $clog2(nthr * nreg) : 1;
    endfunction

endpackage

// File: rtl/bw_r_frf_mt_if.sv
// bw_r_frf_mt_if: FFU control/datapath bundle for the multi-threaded FP register file.
interface bw_r_frf_mt_if #(
    parameter int DATA_W = 78,
    parameter int NTHR   = 4,
    parameter int NREG   = 32
);
    import bw_frf_pkg::*;

    localparam int ADDR_W = addr_w(NTHR, NREG);

    logic              wr_inhibit;
    logic [1:0]        ctl_frf_wen;
    logic [ADDR_W-1:0] ctl_frf_waddr;
    logic [DATA_W-1:0] dp_frf_wdata;
    logic              ctl_frf_ren_a;
    logic              ctl_frf_ren_b;
    logic [ADDR_W-1:0] ctl_frf_raddr_a;
    logic [ADDR_W-1:0] ctl_frf_raddr_b;
    logic [DATA_W-1:0] frf_dp_rdata_a;
    logic [DATA_W-1:0] frf_dp_rdata_b;
    logic              frf_dp_rvld_a;
    logic              frf_dp_rvld_b;

    modport master (
        output wr_inhibit, ctl_frf_wen, ctl_frf_waddr, dp_frf_wdata,
        output ctl_frf_ren_a, ctl_frf_ren_b, ctl_frf_raddr_a, ctl_frf_raddr_b,
        input  frf_dp_rdata_a, frf_dp_rdata_b, frf_dp_rvld_a, frf_dp_rvld_b
    );

    modport slave (
        input  wr_inhibit, ctl_frf_wen, ctl_frf_waddr, dp_frf_wdata,
        input  ctl_frf_ren_a, ctl_frf_ren_b, ctl_frf_raddr_a, ctl_frf_raddr_b,
        output frf_dp_rdata_a, frf_dp_rdata_b, frf_dp_rvld_a, frf_dp_rvld_b
    );

endinterface

// File: rtl/bw_r_frf_mt_half.sv
// bw_r_frf_half: one half-width bank with a write port, two combinational read ports,
// per-entry valid bits and same-cycle write-to-read bypass.
module bw_r_frf_half #(
    parameter int HALF_W = 39,
    parameter int NENT   = 128,
    parameter int AW     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [HALF_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [HALF_W-1:0] rdata_a,
    output logic [HALF_W-1:0] rdata_b
);

    logic [HALF_W-1:0] mem_q [NENT];
    logic [NENT-1:0]   vld_q;
    logic [NENT-1:0]   vld_d;

    always_comb begin
        vld_d = vld_q;
        if (we) vld_d[waddr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    // Storage is deliberately unreset; the valid bits mask stale contents.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    always_comb begin
        rdata_a = (we && waddr == raddr_a) ? wdata : (vld_q[raddr_a] ? mem_q[raddr_a] : '0);
        rdata_b = (we && waddr == raddr_b) ? wdata : (vld_q[raddr_b] ? mem_q[raddr_b] : '0);
    end

endmodule

// File: rtl/bw_r_frf_mt.sv
// bw_r_frf_mt: multi-threaded FP register file, 1 write (per-half) + 2 read ports,
// registered inputs and outputs for a two-edge read latency.
module bw_r_frf_mt
    import bw_frf_pkg::*;
#(
    parameter int DATA_W = 78,
    parameter int NTHR   = 4,
    parameter int NREG   = 32
) (
    input logic          rclk,
    input logic          rst,
    bw_r_frf_mt_if.slave frf
);

    localparam int HALF_W = half_w(DATA_W);
    localparam int NENT   = NTHR * NREG;
    localparam int ADDR_W = addr_w(NTHR, NREG);

    logic              ren_a_q, ren_b_q, inhibit_q;
    logic [1:0]        wen_q;
    logic [ADDR_W-1:0] waddr_q, raddr_a_q, raddr_b_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        we;
    logic [HALF_W-1:0] hi_a, hi_b, lo_a, lo_b;
    logic [DATA_W-1:0] rdata_a_d, rdata_b_d, rdata_a_q, rdata_b_q;
    logic              rvld_a_d, rvld_b_d, rvld_a_q, rvld_b_q;

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            ren_a_q   <= 1'b0;
            ren_b_q   <= 1'b0;
            inhibit_q <= 1'b0;
            wen_q     <= '0;
            waddr_q   <= '0;
            raddr_a_q <= '0;
            raddr_b_q <= '0;
            wdata_q   <= '0;
        end else begin
            ren_a_q   <= frf.ctl_frf_ren_a;
            ren_b_q   <= frf.ctl_frf_ren_b;
            inhibit_q <= frf.wr_inhibit;
            wen_q     <= frf.ctl_frf_wen;
            waddr_q   <= frf.ctl_frf_waddr;
            raddr_a_q <= frf.ctl_frf_raddr_a;
            raddr_b_q <= frf.ctl_frf_raddr_b;
            wdata_q   <= frf.dp_frf_wdata;
        end
    end

    // Inhibit gates the bank write enables, which also suppresses bypass.
    always_comb we = inhibit_q ? 2'b00 : wen_q;

    bw_r_frf_half #(.HALF_W(HALF_W), .NENT(NENT), .AW(ADDR_W)) u_hi (
        .clk     (rclk),
        .rst     (rst),
        .we      (we[HI]),
        .waddr   (waddr_q),
        .wdata   (wdata_q[HI*HALF_W +: HALF_W]),
        .raddr_a (raddr_a_q),
        .raddr_b (raddr_b_q),
        .rdata_a (hi_a),
        .rdata_b (hi_b)
    );

    bw_r_frf_half #(.HALF_W(HALF_W), .NENT(NENT), .AW(ADDR_W)) u_lo (
        .clk     (rclk),
        .rst     (rst),
        .we      (we[LO]),
        .waddr   (waddr_q),
        .wdata   (wdata_q[LO*HALF_W +: HALF_W]),
        .raddr_a (raddr_a_q),
        .raddr_b (raddr_b_q),
        .rdata_a (lo_a),
        .rdata_b (lo_b)
    );

    always_comb begin
        rvld_a_d  = ren_a_q;
        rvld_b_d  = ren_b_q;
        rdata_a_d = ren_a_q ? {hi_a, lo_a} : '0;
        rdata_b_d = ren_b_q ? {hi_b, lo_b} : '0;
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            rvld_a_q  <= 1'b0;
            rvld_b_q  <= 1'b0;
        end else begin
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            rvld_a_q  <= rvld_a_d;
            rvld_b_q  <= rvld_b_d;
        end
    end

    assign frf.frf_dp_rdata_a = rdata_a_q;
    assign frf.frf_dp_rdata_b = rdata_b_q;
    assign frf.frf_dp_rvld_a  = rvld_a_q;
    assign frf.frf_dp_rvld_b  = rvld_b_q;

endmodule

// File: tb/tb_bw_r_frf_mt.sv
// tb_bw_r_frf_mt: directed self-checking bench for the multi-threaded FP register file.
module tb_bw_r_frf_mt;

    localparam int DW = 78;
    localparam int HW = 39;

    logic rclk = 1'b0;
    logic rst  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] v7, ones, p12, x0, w100, exp;

    bw_r_frf_mt_if #(.DATA_W(DW), .NTHR(4), .NREG(32)) frf ();

    bw_r_frf_mt #(.DATA_W(DW), .NTHR(4), .NREG(32)) dut (
        .rclk (rclk),
        .rst  (rst),
        .frf  (frf)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic idle();
        frf.wr_inhibit      = 1'b0;
        frf.ctl_frf_wen     = 2'b00;
        frf.ctl_frf_waddr   = '0;
        frf.dp_frf_wdata    = '0;
        frf.ctl_frf_ren_a   = 1'b0;
        frf.ctl_frf_ren_b   = 1'b0;
        frf.ctl_frf_raddr_a = '0;
        frf.ctl_frf_raddr_b = '0;
    endtask

    task automatic wr(input logic [6:0] a, input logic [1:0] wen, input logic [DW-1:0] d);
        frf.ctl_frf_wen   = wen;
        frf.ctl_frf_waddr = a;
        frf.dp_frf_wdata  = d;
        tick();
        idle();
        tick();
    endtask

    task automatic rd(input logic ea, input logic [6:0] aa, input logic eb, input logic [6:0] ab);
        frf.ctl_frf_ren_a   = ea;
        frf.ctl_frf_raddr_a = aa;
        frf.ctl_frf_ren_b   = eb;
        frf.ctl_frf_raddr_b = ab;
        tick();
        idle();
        tick();
    endtask

    initial begin
        v7   = 78'h3_A5A5_A5A5_A5A5_A5A5_A5;
        ones = {DW{1'b1}};
        p12  = 78'h2B_CDEF_0123_4567_89AB;
        x0   = 78'h15_5555_AAAA_5555_AAAA;
        w100 = 78'h3F_0F0F_1234_5678_9ABC;
        idle();
        tick();
        tick();
        chk("rst_rdata_a", frf.frf_dp_rdata_a, '0);
        chk("rst_rdata_b", frf.frf_dp_rdata_b, '0);
        chk("rst_rvld_a", {77'd0, frf.frf_dp_rvld_a}, '0);
        chk("rst_rvld_b", {77'd0, frf.frf_dp_rvld_b}, '0);
        rst = 1'b0;

        // Unwritten entry reads as zero with valid set, then no stale valid.
        frf.ctl_frf_ren_a   = 1'b1;
        frf.ctl_frf_raddr_a = 7'd5;
        tick();
        idle();
        chk("lat_rvld_a_early", {77'd0, frf.frf_dp_rvld_a}, '0);
        tick();
        chk("unw_rvld_a", {77'd0, frf.frf_dp_rvld_a}, 78'd1);
        chk("unw_rdata_a", frf.frf_dp_rdata_a, '0);
        chk("unw_rvld_b", {77'd0, frf.frf_dp_rvld_b}, '0);
        tick();
        chk("drop_rvld_a", {77'd0, frf.frf_dp_rvld_a}, '0);

        wr(7'd7, 2'b11, v7);
        rd(1'b1, 7'd7, 1'b1, 7'd7);
        chk("full_rdata_a", frf.frf_dp_rdata_a, v7);
        chk("full_rdata_b", frf.frf_dp_rdata_b, v7);
        chk("full_rvld_a", {77'd0, frf.frf_dp_rvld_a}, 78'd1);
        chk("full_rvld_b", {77'd0, frf.frf_dp_rvld_b}, 78'd1);

        wr(7'd9, 2'b11, ones);
        wr(7'd9, 2'b01, '0);
        rd(1'b1, 7'd9, 1'b0, 7'd0);
        chk("half_lo_write", frf.frf_dp_rdata_a, {{HW{1'b1}}, {HW{1'b0}}});
        chk("idle_b_zero", frf.frf_dp_rdata_b, '0);

        // High-half write with a same-cycle read of the same entry.
        wr(7'd12, 2'b11, p12);
        frf.ctl_frf_wen     = 2'b10;
        frf.ctl_frf_waddr   = 7'd12;
        frf.dp_frf_wdata    = {39'h1234, {HW{1'b1}}};
        frf.ctl_frf_ren_a   = 1'b1;
        frf.ctl_frf_raddr_a = 7'd12;
        tick();
        idle();
        tick();
        exp = {39'h1234, p12[HW-1:0]};
        chk("bypass_rdata_a", frf.frf_dp_rdata_a, exp);
        rd(1'b0, 7'd0, 1'b1, 7'd12);
        chk("bypass_persist_b", frf.frf_dp_rdata_b, exp);

        wr(7'd3, 2'b11, x0);
        frf.wr_inhibit      = 1'b1;
        frf.ctl_frf_wen     = 2'b11;
        frf.ctl_frf_waddr   = 7'd3;
        frf.dp_frf_wdata    = ones;
        frf.ctl_frf_ren_a   = 1'b1;
        frf.ctl_frf_raddr_a = 7'd3;
        tick();
        idle();
        tick();
        chk("inhibit_no_bypass", frf.frf_dp_rdata_a, x0);
        rd(1'b1, 7'd3, 1'b0, 7'd0);
        chk("inhibit_no_write", frf.frf_dp_rdata_a, x0);

        wr(7'd20, 2'b10, ones);
        rd(1'b1, 7'd20, 1'b1, 7'd21);
        chk("unw_lo_half", frf.frf_dp_rdata_a, {{HW{1'b1}}, {HW{1'b0}}});
        chk("unw_neighbor", frf.frf_dp_rdata_b, '0);

        // Thread 3, reg 4 -> entry 100; reset lands while a read is in flight.
        wr(7'd100, 2'b11, w100);
        rd(1'b0, 7'd0, 1'b1, 7'd100);
        chk("t3_before_rst", frf.frf_dp_rdata_b, w100);
        frf.ctl_frf_ren_b   = 1'b1;
        frf.ctl_frf_raddr_b = 7'd100;
        tick();
        tick();
        chk("inflight_rvld_b_pre", {77'd0, frf.frf_dp_rvld_b}, 78'd1);
        idle();
        #2 rst = 1'b1;
        #1;
        chk("midrst_rvld_b", {77'd0, frf.frf_dp_rvld_b}, '0);
        chk("midrst_rdata_b", frf.frf_dp_rdata_b, '0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("postrst_rvld_b", {77'd0, frf.frf_dp_rvld_b}, '0);
        chk("postrst_rdata_b", frf.frf_dp_rdata_b, '0);
        rd(1'b0, 7'd0, 1'b1, 7'd100);
        chk("t3_after_rst_rvld", {77'd0, frf.frf_dp_rvld_b}, 78'd1);
        chk("t3_after_rst_data", frf.frf_dp_rdata_b, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bw_r_frf_mt.md
Name: bw_r_frf_mt

Overview:
Parametrised, multi-threaded successor to the single-port floating-point register file. It provides one write port with per-half (high/low) enables and two independent read ports (A, B), so the FFU can fetch rs1/rs2 in the same cycle. Each entry is DATA_W wide (data plus ECC) and is split into two halves so single-precision writes touch one half only. It sits between the FFU control (address/enables) and the FFU datapath (read/write data), with registered inputs and registered outputs.

Parameters:
DATA_W, 78, entry width (data+ECC); must be even; HALF_W = DATA_W/2.
NTHR, 4, hardware threads; power of 2, >=1.
NREG, 32, double-word registers per thread; power of 2.
ADDR_W, log2(NTHR*NREG), derived, not overridable.

Ports:
rclk  in  1  clock, all state on posedge.
rst  in  1  asynchronous, active-high reset.
wr_inhibit  in  1  blocks array writes while 1 (test/reset tristate window).
ctl_frf_wen  in  2  write enable, [1]=high half, [0]=low half.
ctl_frf_waddr  in  ADDR_W  write address {thread, reg}.
dp_frf_wdata  in  DATA_W  write data.
ctl_frf_ren_a / ctl_frf_ren_b  in  1  read enables.
ctl_frf_raddr_a / ctl_frf_raddr_b  in  ADDR_W  read addresses.
frf_dp_rdata_a / frf_dp_rdata_b  out  DATA_W  read data.
frf_dp_rvld_a / frf_dp_rvld_b  out  1  read data valid.

Behaviour:
- Stage 1 (input flops): all ctl/dp inputs registered at posedge N (the *_d1 signals).
- Stage 2: array read is combinational on *_d1 addresses. Result is registered into the outputs at posedge N+1, so read latency is 2 edges (request sampled at N, data and valid visible after N+1).
- Write: at posedge N+1 using *_d1, for each half h where wen_d1[h]=1 and wr_inhibit_d1=0, array[waddr_d1].h <= wdata_d1.h.
- Write/read collision, same address in the same d1 cycle: bypass. The read returns wdata_d1 for each half being written and array contents for the other half. This is never X. The original block's "read+write = X / write suppressed" rule is removed; reads and writes are fully concurrent.
- Inhibited write: no bypass; the read returns array contents.
- Per-half valid bits (2 per entry): cleared by rst, set on write. A read of a never-written half returns 0s for that half. Bypass overrides.
- Port A and B are independent. Same address on both ports returns identical data.
- A port with ren_d1=0 drives rdata=0 and rvld=0 on the next edge; it never holds stale data.
- Reset, asynchronous and immediate: all *_d1 control flops go to 0 (ren, wen, wr_inhibit) and rdata_a/b=0, rvld_a/b=0. Valid bits clear. Array data is not reset.
- A read in flight when rst asserts is dropped; no rvld pulse follows rst deassertion.
- rst deasserted: the first request sampled at the next posedge behaves normally.
- Address wrap: none; every ADDR_W value is a legal entry (NTHR*NREG entries).
- No ECC check/correct here; ECC bits are stored opaquely.

Decomposition:
- Package bw_frf_pkg holds the HALF_W computation, the ADDR_W clog2 function, and the half-select constants HI=1, LO=0.
- Sub-module bw_r_frf_half: one HALF_W x (NTHR*NREG) bank with one write port, two combinational read ports, per-entry valid bits and same-cycle bypass. It is instantiated twice (high, low).
- Top level holds the input/output flops and the enable gating.

Test Plan:
- Reset then read: rst pulse, ren_a=1 raddr_a=5 -> after 2 edges rvld_a=1, rdata_a=0 (unwritten).
- Full write/readback: wen=2'b11 waddr=7 wdata=78'h3_A5A5_A5A5_A5A5_A5A5_A5 -> read addr 7 on both ports -> both return that value, rvld_a=rvld_b=1, 2-edge latency.
- Half write: preload addr 9 with all 1s, then wen=2'b01 wdata=0 -> read 9 returns high half all 1s, low half 0.
- Same-cycle bypass: wen=2'b10 waddr=12 wdata high=39'h1234, with ren_a addr 12 in the same cycle -> rdata_a high=39'h1234, low=prior array value.
- Inhibit: wr_inhibit=1 during a write to addr 3 (previous value X0) -> later read returns X0; bypass is not applied.
- Mid-flight reset: issue ren_b at edge N, assert rst between N and N+1 -> rvld_b and rdata_b are 0 immediately and stay 0 after rst drops; a thread-3 entry written before reset reads 0 (valid cleared).
